// File: rtl/ubrbs_iter_sub_if.sv
// ---------------------------------------------------------------------------
// ubrbs_iter_sub_if
// Operand/result bus for the iterative ripple-borrow subtractor.
//
// Signals:
//   in_valid  master->slave  operands present
//   in_ready  slave->master  subtractor can accept operands
//   x, y      master->slave  minuend / subtrahend, unsigned, WIDTH bits
//   bin       master->slave  borrow-in
//   out_valid slave->master  result present
//   out_ready master->slave  consumer accepts result
//   d         slave->master  difference, modulo 2^WIDTH
//   bout      slave->master  borrow-out
//   ovf       slave->master  signed overflow (only with UBRBS_SIGNED_OVF_EN)
//
// Modports:
//   master : the operand source / result sink around the subtractor
//   slave  : the subtractor itself
//
// Build option: define UBRBS_SIGNED_OVF_EN to add the ovf signal.
// ---------------------------------------------------------------------------
interface ubrbs_iter_sub_if #(
  parameter int WIDTH = 18
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
`ifdef UBRBS_SIGNED_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid,
    input  in_ready,
    output x,
    output y,
    output bin,
    input  out_valid,
    output out_ready,
    input  d,
`ifdef UBRBS_SIGNED_OVF_EN
    input  ovf,
`endif
    input  bout
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  x,
    input  y,
    input  bin,
    output out_valid,
    input  out_ready,
    output d,
`ifdef UBRBS_SIGNED_OVF_EN
    output ovf,
`endif
    output bout
  );

endinterface

// File: rtl/ubrbs_iter_sub.sv
// ---------------------------------------------------------------------------
// ubrbs_iter_sub
// Multi-cycle unsigned ripple-borrow subtractor: D = X - Y - Bin over WIDTH
// bits, CHUNK bits per clock. The borrow between chunks is carried in a
// registered borrow flop, so the combinational path is one CHUNK-bit ripple.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    ubrbs_iter_sub_if.slave
//            in_valid/in_ready   operand handshake (x, y, bin sampled on accept)
//            out_valid/out_ready result handshake (d, bout held under backpressure)
//            ovf                 signed overflow, only with UBRBS_SIGNED_OVF_EN
//
// Parameters:
//   WIDTH  operand / difference width (default 18)
//   CHUNK  bits per RUN cycle; must divide WIDTH (default 6)
//
// Timing: out_valid rises NCHUNK edges after the accept edge. in_ready
// returns high the cycle after the output handshake; operations never overlap.
//
// Build option: define UBRBS_SIGNED_OVF_EN to add the ovf output, the
// two's-complement overflow of x - y - bin, registered with the last chunk.
// ---------------------------------------------------------------------------
module ubrbs_iter_sub #(
  parameter int WIDTH = 18,
  parameter int CHUNK = 6
) (
  input logic              clk,
  input logic              rst_n,
  ubrbs_iter_sub_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int MSB    = WIDTH - 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A chunk size that does not tile the word would leave high bits unprocessed.
  generate
    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
      $error("ubrbs_iter_sub: CHUNK must be >= 1 and divide WIDTH");
    end
  endgenerate

  // One CHUNK-bit ripple-borrow slice. Returns {borrow_out, diff}.
  function automatic logic [CHUNK:0] sub_chunk(
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b,
    input logic             bi
  );
    logic [CHUNK-1:0] diff;
    logic             brw;
    diff = {CHUNK{1'b0}};
    brw  = bi;
    for (int i = 0; i < CHUNK; i++) begin
      diff[i] = a[i] ^ b[i] ^ brw;
      brw     = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw);
    end
    return {brw, diff};
  endfunction

  // Two's-complement overflow of a - b given the result's sign bit.
  function automatic logic signed_ovf(
    input logic a_msb,
    input logic b_msb,
    input logic d_msb
  );
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [IDX_W-1:0] idx_r;
  logic             borrow_r;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] d_r;
  logic             bout_r;
  logic             in_ready_r;
  logic             out_valid_r;
`ifdef UBRBS_SIGNED_OVF_EN
  logic             ovf_r;
`endif

  logic             accept_s;
  logic             release_s;
  logic             last_s;
  logic [CHUNK-1:0] x_slice_s;
  logic [CHUNK-1:0] y_slice_s;
  logic [CHUNK:0]   slice_res_s;
  logic [CHUNK-1:0] diff_slice_s;
  logic             slice_borrow_s;

  // Handshake qualifiers and the current slice computation.
  always_comb begin
    accept_s       = bus.in_valid & in_ready_r & (state_r == ST_IDLE);
    release_s      = bus.out_ready & out_valid_r & (state_r == ST_DONE);
    last_s         = (idx_r == IDX_LAST);
    x_slice_s      = x_r[idx_r*CHUNK +: CHUNK];
    y_slice_s      = y_r[idx_r*CHUNK +: CHUNK];
    slice_res_s    = sub_chunk(x_slice_s, y_slice_s, borrow_r);
    diff_slice_s   = slice_res_s[CHUNK-1:0];
    slice_borrow_s = slice_res_s[CHUNK];
  end

  // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (release_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, slice iteration and result/handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r       <= IDX_ZERO;
      borrow_r    <= 1'b0;
      x_r         <= {WIDTH{1'b0}};
      y_r         <= {WIDTH{1'b0}};
      d_r         <= {WIDTH{1'b0}};
      bout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
`ifdef UBRBS_SIGNED_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            x_r        <= bus.x;
            y_r        <= bus.y;
            borrow_r   <= bus.bin;
            idx_r      <= IDX_ZERO;
            in_ready_r <= 1'b0;
          end
        end
        ST_RUN: begin
          // d fills in slice by slice; it only means something once out_valid is up.
          d_r[idx_r*CHUNK +: CHUNK] <= diff_slice_s;
          borrow_r                  <= slice_borrow_s;
          if (last_s) begin
            bout_r      <= slice_borrow_s;
            out_valid_r <= 1'b1;
            idx_r       <= IDX_ZERO;
`ifdef UBRBS_SIGNED_OVF_EN
            // The last slice carries the MSB, so its top diff bit is d[MSB].
            ovf_r       <= signed_ovf(x_r[MSB], y_r[MSB], diff_slice_s[CHUNK-1]);
`endif
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        ST_DONE: begin
          // in_ready rises on the handshake edge, so it is seen only the cycle after.
          if (release_s) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          idx_r       <= IDX_ZERO;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.d         = d_r;
  assign bus.bout      = bout_r;
`ifdef UBRBS_SIGNED_OVF_EN
  assign bus.ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_ubrbs_iter_sub.sv
// ---------------------------------------------------------------------------
// tb_ubrbs_iter_sub
// Directed bench for ubrbs_iter_sub with hand-computed expected results.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_ubrbs_iter_sub;

  localparam int WIDTH = 18;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  ubrbs_iter_sub_if #(.WIDTH(WIDTH)) bus ();

  ubrbs_iter_sub #(.WIDTH(WIDTH), .CHUNK(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report a mismatch.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation: accept, wait for result (bounded), hold for `hold`
  // cycles of backpressure, then complete the output handshake.
  task automatic run_op(input string tag,
                        input logic [17:0] xv, input logic [17:0] yv, input logic bv,
                        input logic [17:0] ed, input logic eb, input logic eo,
                        input int hold, input logic poke_in_valid);
    int lat;
    $display("op %s: x=0x%05h y=0x%05h bin=%0d expect d=0x%05h bout=%0d ovf=%0d",
             tag, xv, yv, bv, ed, eb, eo);
    @(negedge clk);
    check({tag, " in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.x        = xv;
    bus.y        = yv;
    bus.bin      = bv;
    @(posedge clk);
    #1;
    // Scramble the operands: only the accept-edge values may count.
    bus.in_valid = 1'b0;
    bus.x        = ~xv;
    bus.y        = 18'h2B3C1;
    bus.bin      = ~bv;
    check({tag, " in_ready_run"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd3);
    check({tag, " d"}, 32'(bus.d), 32'(ed));
    check({tag, " bout"}, 32'(bus.bout), 32'(eb));
`ifdef UBRBS_SIGNED_OVF_EN
    check({tag, " ovf"}, 32'(bus.ovf), 32'(eo));
`endif
    if (poke_in_valid) begin
      bus.in_valid = 1'b1;
    end else begin
      bus.in_valid = 1'b0;
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check({tag, " hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, " hold_d"}, 32'(bus.d), 32'(ed));
      check({tag, " hold_bout"}, 32'(bus.bout), 32'(eb));
      check({tag, " hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, " out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, " in_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x         = 18'h00000;
    bus.y         = 18'h00000;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;

    #12;
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst d", 32'(bus.d), 32'd0);
    check("rst bout", 32'(bus.bout), 32'd0);
`ifdef UBRBS_SIGNED_OVF_EN
    check("rst ovf", 32'(bus.ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_op("dec",     18'h3FFFF, 18'h00001, 1'b0, 18'h3FFFE, 1'b0, 1'b0, 0, 1'b0);
    run_op("wrap",    18'h00000, 18'h00001, 1'b0, 18'h3FFFF, 1'b1, 1'b0, 0, 1'b0);
    run_op("eq_bin1", 18'h12345, 18'h12345, 1'b1, 18'h3FFFF, 1'b1, 1'b0, 0, 1'b0);
    run_op("eq_bin0", 18'h12345, 18'h12345, 1'b0, 18'h00000, 1'b0, 1'b0, 0, 1'b0);
    run_op("bp",      18'h2AAAA, 18'h15555, 1'b0, 18'h15555, 1'b0, 1'b1, 10, 1'b1);
    run_op("mixed",   18'h0F0F0, 18'h00F0F, 1'b1, 18'h0E1E0, 1'b0, 1'b0, 2, 1'b0);

    // Reset one cycle into RUN: everything returns to reset values at once.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x        = 18'h3FFFF;
    bus.y        = 18'h00001;
    bus.bin      = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst d", 32'(bus.d), 32'd0);
    check("midrst bout", 32'(bus.bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("midrst no_result", 32'(bus.out_valid), 32'd0);
    end

    run_op("post_rst", 18'h00005, 18'h00003, 1'b0, 18'h00002, 1'b0, 1'b0, 0, 1'b0);
    run_op("sovf",     18'h1FFFF, 18'h20000, 1'b0, 18'h3FFFF, 1'b1, 1'b1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
